// File: rtl/alu_operand_issuer.sv
// alu_operand_issuer
// Initiator-side sequencer for the DA_CU datapath/control unit. Takes one
// operand pair at a time from a valid/ready request port, serialises it onto
// the unit's data input (start + A, then B), waits for the unit's done strobe
// under a watchdog, and returns the captured result on a valid/ready
// response port. Completion and timeout counters aid bring-up.
module alu_operand_issuer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_din,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [7:0]       done_cnt,
    output logic [7:0]       tmo_cnt
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Watchdog limit in the wait counter's width (TIMEOUT is 1..255)
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Index of each event counter in the counter bank
    localparam int CNT_DONE = 0;
    localparam int CNT_TMO  = 1;

    logic [2:0]       state_reg,       state_next;
    logic [WIDTH-1:0] op_a_reg,        op_a_next;
    logic [WIDTH-1:0] op_b_reg,        op_b_next;
    logic [7:0]       wait_cnt_reg,    wait_cnt_next;
    logic             alu_start_reg,   alu_start_next;
    logic [WIDTH-1:0] alu_din_reg,     alu_din_next;
    logic             rsp_valid_reg,   rsp_valid_next;
    logic [WIDTH-1:0] rsp_data_reg,    rsp_data_next;
    logic             rsp_timeout_reg, rsp_timeout_next;

    // Per-counter increment requests and the resulting counter values
    logic [1:0]       cnt_inc;
    logic [7:0]       cnt_val [2];

    // Wait counter value as it will be after this WAIT cycle
    logic [7:0]       wait_inc;

    assign wait_inc = wait_cnt_reg + 8'd1;

    // Next-state and next-output decode for the whole sequencer
    always_comb begin
        state_next       = state_reg;
        op_a_next        = op_a_reg;
        op_b_next        = op_b_reg;
        wait_cnt_next    = wait_cnt_reg;
        alu_start_next   = 1'b0;
        alu_din_next     = alu_din_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        cnt_inc          = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                // req_ready is 1 here, so req_valid alone completes the handshake
                if (req_valid) begin
                    op_a_next      = req_a;
                    op_b_next      = req_b;
                    alu_start_next = 1'b1;
                    alu_din_next   = req_a;
                    state_next     = ST_LOAD_A;
                end
            end

            ST_LOAD_A: begin
                // Start pulse ends after one cycle; present operand B next
                alu_start_next = 1'b0;
                alu_din_next   = op_b_reg;
                state_next     = ST_LOAD_B;
            end

            ST_LOAD_B: begin
                alu_din_next  = op_b_reg;
                wait_cnt_next = 8'd0;
                state_next    = ST_WAIT;
            end

            ST_WAIT: begin
                wait_cnt_next = wait_inc;
                // done is checked first so it wins a same-cycle collision
                if (alu_done) begin
                    rsp_valid_next     = 1'b1;
                    rsp_data_next      = alu_dout;
                    rsp_timeout_next   = 1'b0;
                    cnt_inc[CNT_DONE]  = 1'b1;
                    state_next         = ST_RESP;
                end else if (wait_inc == TIMEOUT_CNT) begin
                    rsp_valid_next     = 1'b1;
                    rsp_data_next      = '0;
                    rsp_timeout_next   = 1'b1;
                    cnt_inc[CNT_TMO]   = 1'b1;
                    state_next         = ST_RESP;
                end
            end

            ST_RESP: begin
                // Response fields stay frozen until the consumer takes them
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            wait_cnt_reg    <= 8'd0;
            alu_start_reg   <= 1'b0;
            alu_din_reg     <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_a_reg        <= op_a_next;
            op_b_reg        <= op_b_next;
            wait_cnt_reg    <= wait_cnt_next;
            alu_start_reg   <= alu_start_next;
            alu_din_reg     <= alu_din_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Wrapping 8-bit event counters, bumped only on the WAIT->RESP edge
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_evt_cnt
            logic [7:0] cnt_reg;

            // One counter per event kind; wraps 255 -> 0 naturally
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= 8'd0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    // Registered outputs
    assign alu_start   = alu_start_reg;
    assign alu_din     = alu_din_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign done_cnt    = cnt_val[CNT_DONE];
    assign tmo_cnt     = cnt_val[CNT_TMO];

    // State decodes
    assign req_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_operand_issuer.sv
// Directed, table-driven bench for alu_operand_issuer. The table holds
// operand pairs, the WAIT cycle of the done strobe, backpressure length and
// hand-computed result, timeout flag and request-to-response latency.
module tb_alu_operand_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       alu_start;
    logic [3:0] alu_din;
    logic [3:0] alu_dout;
    logic       alu_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic [7:0] done_cnt;
    logic [7:0] tmo_cnt;

    alu_operand_issuer #(.WIDTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .alu_start(alu_start), .alu_din(alu_din),
        .alu_dout(alu_dout), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .done_cnt(done_cnt), .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         k;        // WAIT cycle carrying alu_done, 0 = never
        logic [3:0] dout;     // value on alu_dout throughout
        int         stall;    // cycles rsp_ready held low in RESP
        bit         hold;     // keep req_valid high with the next pair
        logic [3:0] exp_data;
        logic       exp_tmo;
        int         exp_lat;  // edges from accept to rsp_valid
    } vec_t;

    vec_t vecs [6];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_done = 8'd0;
    logic [7:0] exp_tmo_n = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake
    task automatic run_txn(input vec_t v, input logic [3:0] na, input logic [3:0] nb);
        int c;
        bit got;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        alu_dout  = v.dout;
        alu_done  = 1'b0;
        rsp_ready = 1'b0;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        got = 1'b0;
        c   = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (c == 1) begin
                    check("load_a_start", 32'(alu_start), 32'd1);
                    check("load_a_din", 32'(alu_din), 32'(v.a));
                    if (v.hold) begin
                        req_a = na;
                        req_b = nb;
                    end else begin
                        req_valid = 1'b0;
                    end
                end else begin
                    check("start_low", 32'(alu_start), 32'd0);
                    check("din_b", 32'(alu_din), 32'(v.b));
                end
                check("req_ready_busy", 32'(req_ready), 32'd0);
                check("busy_high", 32'(busy), 32'd1);
                alu_done = (v.k != 0 && c == 2 + v.k);
            end
        end
        alu_done = 1'b0;
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", 32'(c), 32'(v.exp_lat));
        check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
        check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_tmo));
        if (v.exp_tmo) exp_tmo_n = exp_tmo_n + 8'd1;
        else           exp_done  = exp_done + 8'd1;
        check("done_cnt", 32'(done_cnt), 32'(exp_done));
        check("tmo_cnt", 32'(tmo_cnt), 32'(exp_tmo_n));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'(v.exp_data));
            check("stall_tmo", 32'(rsp_timeout), 32'(v.exp_tmo));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
        $display("txn a=%0h b=%0h k=%0d -> data=%0h tmo=%0b lat=%0d done_cnt=%0d tmo_cnt=%0d",
                 v.a, v.b, v.k, rsp_data, rsp_timeout, c, done_cnt, tmo_cnt);
    endtask

    // Checks every reset-value output at the current sample point
    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(alu_start), 32'd0);
        check({tag, "_din"}, 32'(alu_din), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_tmo"}, 32'(rsp_timeout), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        check({tag, "_tmo_cnt"}, 32'(tmo_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t w;
        int c;
        bit got;

        //           a     b     k   dout stall hold  data  tmo lat
        vecs[0] = '{4'h3, 4'h4, 2,  4'h7, 0, 1'b0, 4'h7, 1'b0, 5};
        vecs[1] = '{4'h5, 4'h2, 0,  4'hF, 0, 1'b0, 4'h0, 1'b1, 18};
        vecs[2] = '{4'h1, 4'h9, 15, 4'h9, 0, 1'b0, 4'h9, 1'b0, 18};
        vecs[3] = '{4'hA, 4'hC, 1,  4'h6, 6, 1'b1, 4'h6, 1'b0, 4};
        vecs[4] = '{4'h2, 4'hE, 3,  4'hD, 0, 1'b0, 4'hD, 1'b0, 6};
        vecs[5] = '{4'hF, 4'hF, 14, 4'h1, 2, 1'b0, 4'h1, 1'b0, 17};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = 4'h0;
        req_b     = 4'h0;
        alu_dout  = 4'h0;
        alu_done  = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("por_rel");

        // Table: basic, timeout, collision, backpressure with held request, misc
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], (i < 5) ? vecs[i+1].a : 4'h0, (i < 5) ? vecs[i+1].b : 4'h0);
        end

        // Reset during LOAD_B
        req_a = 4'h6; req_b = 4'h7; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("loadb_din", 32'(alu_din), 32'h7);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_loadb");
        rst_n = 1'b1;
        exp_done = 8'd0; exp_tmo_n = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_loadb_no_start", 32'(alu_start), 32'd0);
            check("rst_loadb_idle", 32'(busy), 32'd0);
        end

        // Reset while a response is pending in RESP
        req_a = 4'h8; req_b = 4'h1; req_valid = 1'b1; alu_dout = 4'h5;
        @(posedge clk);
        got = 1'b0; c = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0;
            if (rsp_valid) got = 1'b1;
            alu_done = (c == 3);
        end
        alu_done = 1'b0;
        check("resp_reached", 32'(got), 32'd1);
        check("resp_pending_data", 32'(rsp_data), 32'h5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_resp");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_resp_no_valid", 32'(rsp_valid), 32'd0);
            check("rst_resp_no_start", 32'(alu_start), 32'd0);
        end

        // Fresh request after reset completes normally
        w = '{4'h4, 4'h4, 2, 4'h8, 0, 1'b0, 4'h8, 1'b0, 5};
        run_txn(w, 4'h0, 4'h0);

        // Spurious done strobes in IDLE change nothing
        alu_dout = 4'h3;
        for (int i = 0; i < 3; i++) begin
            alu_done = 1'b1;
            @(negedge clk);
            check("spur_busy", 32'(busy), 32'd0);
            check("spur_valid", 32'(rsp_valid), 32'd0);
            check("spur_done_cnt", 32'(done_cnt), 32'd1);
            check("spur_tmo_cnt", 32'(tmo_cnt), 32'd0);
        end
        alu_done = 1'b0;

        // Counter wrap: reset, then 256 successful transactions
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 8'd0; exp_tmo_n = 8'd0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            w = '{4'(i), 4'(i >> 4), 1, 4'(i + 3), 0, 1'b0, 4'(i + 3), 1'b0, 4};
            run_txn(w, 4'h0, 4'h0);
        end
        check("wrap_done_cnt", 32'(done_cnt), 32'd0);
        check("wrap_tmo_cnt", 32'(tmo_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_issuer.md
# alu_operand_issuer

Initiator-side sequencer that drives the `DA_CU` datapath/control unit. It accepts operand pairs from an upstream valid/ready request port and serialises each pair onto the unit's 4-bit data input: start pulse with operand A, then operand B. It then waits for the unit's done indication, captures the result, and returns it on a valid/ready response port. A watchdog timeout and completion/timeout counters support bring-up and verification of the ALU path.

## Interface
- `WIDTH`, 4: operand and result width; matches the `DA_CU` data path.
- `TIMEOUT`, 15: maximum wait cycles for `alu_done` before the transaction is aborted; valid range 1..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: upstream operand pair valid.
- `req_ready` out 1: issuer can accept a pair.
- `req_a` in WIDTH: operand A.
- `req_b` in WIDTH: operand B.
- `alu_start` out 1: start pulse to the ALU unit.
- `alu_din` out WIDTH: operand bus to the ALU unit's data input.
- `alu_dout` in WIDTH: result bus from the ALU unit.
- `alu_done` in 1: single-cycle result-valid strobe from the ALU unit.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_data` out WIDTH: captured result; 0 on timeout.
- `rsp_timeout` out 1: response is a timeout abort.
- `busy` out 1: FSM not in IDLE.
- `done_cnt` out 8: completed (non-timeout) transactions, wraps 255→0.
- `tmo_cnt` out 8: timed-out transactions, wraps 255→0.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `req_a`/`req_b` into internal registers and go to LOAD_A.
- LOAD_A: `alu_start`=1 and `alu_din`=A for exactly one cycle, then go to LOAD_B.
- LOAD_B: `alu_start`=0 and `alu_din`=B for exactly one cycle. Clear the wait counter and go to WAIT.
- WAIT: `alu_din` holds B. The wait counter increments each cycle.
  - If `alu_done`=1: capture `alu_dout` into `rsp_data`, set `rsp_timeout`=0, increment `done_cnt`, go to RESP.
  - Else, if the counter reaches `TIMEOUT`: set `rsp_data`=0 and `rsp_timeout`=1, increment `tmo_cnt`, go to RESP.
  - If `alu_done` arrives in the same cycle the counter reaches `TIMEOUT`, done wins.
- RESP: `rsp_valid`=1, with `rsp_data` and `rsp_timeout` held stable until `rsp_valid`&&`rsp_ready`. On that handshake, return to IDLE.
- `alu_done` outside WAIT is ignored and counts nothing.
- `req_ready`=0 in every state except IDLE. There is no request pipelining: one transaction is outstanding at most.
- Outputs are registered, except `req_ready` and `busy`, which decode the state register.

## Timing
- Reset (`rst_n`=0 at a rising edge), applied in any state, including mid-transaction:
  - state→IDLE.
  - `alu_start`, `alu_din`, `rsp_valid`, `rsp_data`, `rsp_timeout` all 0.
  - `done_cnt`=`tmo_cnt`=0.
  - `busy`=0 and `req_ready`=1 from the first cycle after reset releases.
  - A pending response is discarded, and no start is re-issued.
- Accept at edge N gives LOAD_A during cycle N+1 (`alu_start`=1) and LOAD_B during N+2. WAIT begins at N+3.
- With `alu_done` in the k-th WAIT cycle (k≥1), `rsp_valid` rises at the next edge.
  - Request-to-response latency = 3 + k cycles.
- With no `alu_done`, `rsp_valid` rises after `TIMEOUT` WAIT cycles, so latency = 3 + `TIMEOUT`.
- Back-to-back transactions: after the RESP handshake at edge M, IDLE is active in cycle M+1. The next accept is at the earliest edge M+1.
- Minimum transaction period = 5 cycles (IDLE, LOAD_A, LOAD_B, 1 WAIT, RESP).
- Counters increment on the WAIT→RESP transition edge only.

## Test plan
- Basic pass:
  - Stimulus: A=3, B=4; `alu_done` pulses on the 2nd WAIT cycle with `alu_dout`=7; `rsp_ready`=1.
  - Required: `alu_start` high exactly one cycle with `alu_din`=3, then `alu_din`=4; `rsp_data`=7, `rsp_timeout`=0; `done_cnt`=1; response 5 cycles after accept.
- Timeout:
  - Stimulus: `TIMEOUT`=15, A=5, B=2, `alu_done` held 0.
  - Required: `rsp_valid` 18 cycles after accept; `rsp_data`=0, `rsp_timeout`=1; `tmo_cnt`=1, `done_cnt` unchanged.
- Done/timeout collision:
  - Stimulus: `alu_done`=1 with `alu_dout`=9 in WAIT cycle 15, `TIMEOUT`=15.
  - Required: `rsp_data`=9, `rsp_timeout`=0; `done_cnt` increments, `tmo_cnt` does not.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 6 cycles in RESP; `req_valid` held high with new operands.
  - Required: `rsp_valid`, `rsp_data`, `rsp_timeout` stable; `req_ready`=0 throughout; after the handshake, the next pair is accepted one cycle later.
- Reset mid-operation:
  - Stimulus: `rst_n`=0 during LOAD_B and separately during RESP.
  - Required: all outputs at reset values next cycle; `alu_start` not re-asserted; counters 0; a fresh request completes normally afterwards.
- Counter wrap and spurious done:
  - Stimulus: 256 successful transactions; `alu_done` pulses while in IDLE.
  - Required: `done_cnt` wraps to 0; the IDLE pulse changes neither state nor counters.
